// File: rtl/ori_bus_pkg.sv
// Shared types for the Orion 8080-style bus master: cycle codes, status bytes, FSM states.
// Status bit map follows the 8080: D7 MEMR, D6 INP, D5 M1, D4 OUT, D1 WO_n.
package ori_bus_pkg;

  typedef enum logic [2:0] {
    CYC_FETCH = 3'd0,
    CYC_MEMRD = 3'd1,
    CYC_MEMWR = 3'd2,
    CYC_IORD  = 3'd3,
    CYC_IOWR  = 3'd4
  } cyc_t;

  localparam logic [7:0] ST_FETCH = 8'hA2;
  localparam logic [7:0] ST_MEMRD = 8'h82;
  localparam logic [7:0] ST_MEMWR = 8'h00;
  localparam logic [7:0] ST_IORD  = 8'h42;
  localparam logic [7:0] ST_IOWR  = 8'h10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_TW   = 3'd3,
    S_T3   = 3'd4
  } state_t;

  // Reserved request codes fall back to a plain memory read.
  function automatic cyc_t decode_type(input logic [2:0] t);
    case (t)
      3'd0:    return CYC_FETCH;
      3'd2:    return CYC_MEMWR;
      3'd3:    return CYC_IORD;
      3'd4:    return CYC_IOWR;
      default: return CYC_MEMRD;
    endcase
  endfunction

  function automatic logic [7:0] status_of(input cyc_t c);
    case (c)
      CYC_FETCH: return ST_FETCH;
      CYC_MEMWR: return ST_MEMWR;
      CYC_IORD:  return ST_IORD;
      CYC_IOWR:  return ST_IOWR;
      default:   return ST_MEMRD;
    endcase
  endfunction

  function automatic logic is_write(input cyc_t c);
    return (c == CYC_MEMWR) || (c == CYC_IOWR);
  endfunction

endpackage

// File: rtl/ori_phase_gen.sv
// Free-running T-state phase counter; f1 pulses while the count is 0, f2 while it is T_DIV/2.
// Both pulses are registered, so they are glitch-free single-clock strobes.
module ori_phase_gen #(
  parameter int T_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic f1,
  output logic f2
);

  localparam int CW = $clog2(T_DIV);

  logic [CW-1:0] cnt;

  // Pulses are decoded one count early so they line up with the count they name.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
      f1  <= 1'b0;
      f2  <= 1'b0;
    end else begin
      cnt <= (cnt == CW'(T_DIV - 1)) ? '0 : cnt + 1'b1;
      f1  <= (cnt == CW'(T_DIV - 1));
      f2  <= (cnt == CW'(T_DIV / 2 - 1));
    end
  end

endmodule

// File: rtl/ori_bus_master.sv
// 8080-style bus cycle generator: one request becomes T1/T2/(TW)/T3 with SYNC, DBIN and WR_n.
// Requests are taken only on f1 in IDLE or at the end of T3, allowing back-to-back cycles.
module ori_bus_master
  import ori_bus_pkg::*;
#(
  parameter int T_DIV  = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_type_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [7:0]        req_wdata_i,
  output logic [7:0]        rdata_o,
  output logic              rdata_valid_o,
  output logic              cpu_f1_o,
  output logic              cpu_f2_o,
  output logic              cpu_sync_o,
  output logic              cpu_dbin_o,
  output logic              cpu_wr_n_o,
  input  logic              cpu_ready_i,
  output logic [ADDR_W-1:0] cpu_addr_o,
  output logic [7:0]        cpu_data_o,
  output logic              cpu_data_oe_o,
  input  logic [7:0]        cpu_data_i
);

  logic f1, f2;
  state_t state, state_nxt;
  cyc_t cyc;
  logic [7:0] wdata_q;
  logic ready_q, accept, is_rd, to_t3;
  logic sync_d, dbin_d, wr_n_d, oe_d, rvld_d;
  logic [7:0] data_d, rdata_d;
  logic [ADDR_W-1:0] addr_d;

  ori_phase_gen #(.T_DIV(T_DIV)) u_phase (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .f1    (f1),
    .f2    (f2)
  );

  assign cpu_f1_o    = f1;
  assign cpu_f2_o    = f2;
  assign req_ready_o = f1 && (state == S_IDLE || state == S_T3);
  assign accept      = req_valid_i && req_ready_o;
  assign is_rd       = !is_write(cyc);
  assign to_t3       = (state_nxt == S_T3) && (state != S_T3);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      cyc     <= CYC_FETCH;
      wdata_q <= 8'h00;
      ready_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cyc     <= decode_type(req_type_i);
        wdata_q <= req_wdata_i;
      end
      if (f2 && (state == S_T2 || state == S_TW))
        ready_q <= cpu_ready_i;
    end
  end

  always_comb begin
    state_nxt = state;
    if (f1) begin
      case (state)
        S_IDLE:  if (accept) state_nxt = S_T1;
        S_T1:    state_nxt = S_T2;
        S_T2:    state_nxt = ready_q ? S_T3 : S_TW;
        S_TW:    if (ready_q) state_nxt = S_T3;
        S_T3:    state_nxt = accept ? S_T1 : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sync_d  = cpu_sync_o;
    dbin_d  = cpu_dbin_o;
    wr_n_d  = cpu_wr_n_o;
    oe_d    = cpu_data_oe_o;
    data_d  = cpu_data_o;
    addr_d  = cpu_addr_o;
    rdata_d = rdata_o;
    rvld_d  = 1'b0;
    if (accept)
      addr_d = req_addr_i;
    if (f2) begin
      case (state)
        S_T1: begin
          sync_d = 1'b1;
          data_d = status_of(cyc);
          oe_d   = 1'b1;
        end
        S_T2: begin
          sync_d = 1'b0;
          if (is_rd) begin
            oe_d   = 1'b0;
            dbin_d = 1'b1;
          end else begin
            data_d = wdata_q;
          end
        end
        S_T3: if (is_rd) begin
          rdata_d = cpu_data_i;
          rvld_d  = 1'b1;
          dbin_d  = 1'b0;
        end
        default: ;
      endcase
    end
    // Write strobe spans exactly T3: dropped on entry, released on the exit f1.
    if (f1) begin
      if (to_t3 && !is_rd)
        wr_n_d = 1'b0;
      if (state == S_T3) begin
        wr_n_d = 1'b1;
        oe_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cpu_sync_o    <= 1'b0;
      cpu_dbin_o    <= 1'b0;
      cpu_wr_n_o    <= 1'b1;
      cpu_data_oe_o <= 1'b0;
      cpu_data_o    <= 8'h00;
      cpu_addr_o    <= '0;
      rdata_o       <= 8'h00;
      rdata_valid_o <= 1'b0;
    end else begin
      cpu_sync_o    <= sync_d;
      cpu_dbin_o    <= dbin_d;
      cpu_wr_n_o    <= wr_n_d;
      cpu_data_oe_o <= oe_d;
      cpu_data_o    <= data_d;
      cpu_addr_o    <= addr_d;
      rdata_o       <= rdata_d;
      rdata_valid_o <= rvld_d;
    end
  end

endmodule
